// File: rtl/dircc_timer_tick_master.sv
// Avalon-MM master that drives one interval timer. It programs the period and
// control registers on start. On every timeout it snapshots and reads the counter,
// then clears the status flag. Each tick goes to node logic as a timestamp plus a
// wrapping count.
module dircc_timer_tick_master #(
  parameter bit          CONTINUOUS = 1'b1,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic [31:0]        cfg_period,
  input  logic               cfg_stop,
  input  logic               irq,
  output logic [2:0]         m_address,
  output logic               m_chipselect,
  output logic               m_write_n,
  output logic [15:0]        m_writedata,
  input  logic [15:0]        m_readdata,
  output logic               busy,
  output logic               tick_valid,
  output logic [31:0]        tick_snapshot,
  output logic [COUNT_W-1:0] tick_count
);

  // Control word: ITO and START always set, CONT only when free-running.
  localparam logic [15:0] CtrlWord = CONTINUOUS ? 16'h0007 : 16'h0005;
  localparam logic [15:0] StopWord = 16'h0008;

  typedef enum logic [3:0] {
    StIdle, StWrPl, StWrPh, StWrCtrl, StWaitIrq, StWrSnap,
    StRdSl, StRdSh, StCap, StWrClr, StReport, StWrStop
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        period_q;
  logic               stop_pending_q;
  logic [15:0]        snap_lo_q, snap_hi_q;
  logic [31:0]        tick_snapshot_q;
  logic [COUNT_W-1:0] tick_count_q;

  // Next-state decode and single-cycle bus strobes, all derived from the state.
  always_comb begin
    state_d      = state_q;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 3'd0;
    m_writedata  = 16'h0000;
    unique case (state_q)
      StIdle: if (cfg_start) state_d = StWrPl;
      StWrPl: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd2;
        m_writedata  = period_q[15:0];
        state_d      = StWrPh;
      end
      StWrPh: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd3;
        m_writedata  = period_q[31:16];
        state_d      = StWrCtrl;
      end
      StWrCtrl: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd1;
        m_writedata  = CtrlWord;
        state_d      = StWaitIrq;
      end
      // A stop request beats a timeout seen in the same cycle.
      StWaitIrq: begin
        if (stop_pending_q || cfg_stop) state_d = StWrStop;
        else if (irq)                   state_d = StWrSnap;
      end
      StWrSnap: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd4;
        state_d      = StRdSl;
      end
      StRdSl: begin
        m_chipselect = 1'b1;
        m_address    = 3'd4;
        state_d      = StRdSh;
      end
      StRdSh: begin
        m_chipselect = 1'b1;
        m_address    = 3'd5;
        state_d      = StCap;
      end
      StCap: state_d = StWrClr;
      StWrClr: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd0;
        state_d      = StReport;
      end
      StReport: begin
        if (stop_pending_q)   state_d = StWrStop;
        else if (!CONTINUOUS) state_d = StIdle;
        else                  state_d = StWaitIrq;
      end
      StWrStop: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 3'd1;
        m_writedata  = StopWord;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Stop request latch. A stop seen mid-service is held until the service finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_pending_q <= 1'b0;
    end else if ((state_q == StIdle && cfg_start) || state_q == StWrStop) begin
      stop_pending_q <= 1'b0;
    end else if (cfg_stop && state_q != StIdle && state_q != StWaitIrq) begin
      stop_pending_q <= 1'b1;
    end
  end

  // Period latch, snapshot capture and tick bookkeeping.
  // Snapshot and count are updated while leaving WR_CLR, so both are already
  // valid during the REPORT cycle that pulses tick_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q        <= 32'h0;
      snap_lo_q       <= 16'h0;
      snap_hi_q       <= 16'h0;
      tick_snapshot_q <= 32'h0;
      tick_count_q    <= '0;
    end else begin
      if (state_q == StIdle && cfg_start) begin
        period_q     <= cfg_period;
        tick_count_q <= '0;
      end
      // The slave's read data is registered, so it lags the address by one cycle.
      if (state_q == StRdSh) snap_lo_q <= m_readdata;
      if (state_q == StCap)  snap_hi_q <= m_readdata;
      if (state_q == StWrClr) begin
        tick_snapshot_q <= {snap_hi_q, snap_lo_q};
        tick_count_q    <= tick_count_q + COUNT_W'(1);
      end
    end
  end

  assign busy          = (state_q != StIdle);
  assign tick_valid    = (state_q == StReport);
  assign tick_snapshot = tick_snapshot_q;
  assign tick_count    = tick_count_q;

endmodule

// File: tb/tb_dircc_timer_tick_master.sv
// Scoreboard bench for dircc_timer_tick_master. It runs a free-running instance with a
// narrow tick counter, so wrap is reached quickly, and a one-shot instance. Stimulus
// tasks push the expected bus accesses and tick reports, each tagged with its cycle.
// One monitor pops and compares these whenever a bus strobe or tick_valid appears.
module tb_dircc_timer_tick_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_start, cfg_stop, irq, sel;
  logic [31:0] cfg_period, counter, snap_q;
  logic [15:0] m_readdata;
  int          cyc = 0;

  // Free-running instance (sel=0) signals.
  logic [2:0]  a_addr;
  logic        a_cs, a_wn, a_busy, a_tv;
  logic [15:0] a_wd;
  logic [31:0] a_snap;
  logic [3:0]  a_cnt;
  // One-shot instance (sel=1) signals.
  logic [2:0]  b_addr;
  logic        b_cs, b_wn, b_busy, b_tv;
  logic [15:0] b_wd;
  logic [31:0] b_snap;
  logic [15:0] b_cnt;

  dircc_timer_tick_master #(.CONTINUOUS(1'b1), .COUNT_W(4)) u_cont (
    .clk(clk), .reset(reset), .cfg_start(cfg_start & ~sel), .cfg_period(cfg_period),
    .cfg_stop(cfg_stop & ~sel), .irq(irq & ~sel), .m_address(a_addr), .m_chipselect(a_cs),
    .m_write_n(a_wn), .m_writedata(a_wd), .m_readdata(m_readdata), .busy(a_busy),
    .tick_valid(a_tv), .tick_snapshot(a_snap), .tick_count(a_cnt)
  );

  dircc_timer_tick_master #(.CONTINUOUS(1'b0), .COUNT_W(16)) u_oneshot (
    .clk(clk), .reset(reset), .cfg_start(cfg_start & sel), .cfg_period(cfg_period),
    .cfg_stop(cfg_stop & sel), .irq(irq & sel), .m_address(b_addr), .m_chipselect(b_cs),
    .m_write_n(b_wn), .m_writedata(b_wd), .m_readdata(m_readdata), .busy(b_busy),
    .tick_valid(b_tv), .tick_snapshot(b_snap), .tick_count(b_cnt)
  );

  wire [2:0]  addr = sel ? b_addr : a_addr;
  wire        cs   = sel ? b_cs : a_cs;
  wire        wn   = sel ? b_wn : a_wn;
  wire [15:0] wd   = sel ? b_wd : a_wd;
  wire        busy = sel ? b_busy : a_busy;
  wire        tv   = sel ? b_tv : a_tv;
  wire [31:0] snap = sel ? b_snap : a_snap;
  wire [15:0] cnt  = sel ? b_cnt : {12'h0, a_cnt};

  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: snapshot write captures the counter; reads return data one cycle later.
  always @(posedge clk) begin
    if (cs && !wn && addr == 3'd4) snap_q <= counter;
    if (cs && wn) m_readdata <= (addr == 3'd4) ? snap_q[15:0] :
                                (addr == 3'd5) ? snap_q[31:16] : 16'h0;
  end

  typedef struct { int c; logic [2:0] a; logic wn; logic [15:0] d; } bus_t;
  typedef struct { int c; logic [31:0] s; logic [15:0] n; } tick_t;
  bus_t  bus_q[$];
  tick_t tick_q[$];
  int    n_checks = 0, n_err = 0, tick_model = 0, ticks_pushed = 0, ticks_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every observed access and tick against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (cs) begin
        if (bus_q.size() == 0) check("bus_unexpected_access", {29'h0, addr}, 32'hFFFF_FFFF);
        else begin
          bus_t e;
          e = bus_q.pop_front();
          check("bus_cycle", 32'(cyc), 32'(e.c));
          check("bus_addr", {29'h0, addr}, {29'h0, e.a});
          check("bus_write_n", {31'h0, wn}, {31'h0, e.wn});
          check("bus_wdata", {16'h0, wd}, {16'h0, e.d});
        end
      end
      if (tv) begin
        ticks_seen++;
        if (tick_q.size() == 0) check("tick_unexpected", 32'h1, 32'h0);
        else begin
          tick_t t;
          t = tick_q.pop_front();
          check("tick_cycle", 32'(cyc), 32'(t.c));
          check("tick_snapshot", snap, t.s);
          check("tick_count", {16'h0, cnt}, {16'h0, t.n});
        end
      end
    end
  end

  task automatic push_bus(input int c, input logic [2:0] a, input logic w_n, input logic [15:0] d);
    bus_t e;
    e.c = c; e.a = a; e.wn = w_n; e.d = d;
    bus_q.push_back(e);
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    return sel ? 16'(n) : 16'(n % 16);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_tick_valid"}, {31'h0, tv}, 32'h0);
    check({tag, "_tick_snapshot"}, snap, 32'h0);
    check({tag, "_tick_count"}, {16'h0, cnt}, 32'h0);
    check({tag, "_chipselect"}, {31'h0, cs}, 32'h0);
    check({tag, "_write_n"}, {31'h0, wn}, 32'h1);
    check({tag, "_address"}, {29'h0, addr}, 32'h0);
    check({tag, "_writedata"}, {16'h0, wd}, 32'h0);
  endtask

  // Called at a negedge with the DUT idle; returns at the first WAIT_IRQ negedge.
  task automatic do_start(input logic [31:0] p);
    int s;
    s = cyc;
    cfg_period = p;
    cfg_start = 1'b1;
    push_bus(s + 1, 3'd2, 1'b0, p[15:0]);
    push_bus(s + 2, 3'd3, 1'b0, p[31:16]);
    push_bus(s + 3, 3'd1, 1'b0, sel ? 16'h0005 : 16'h0007);
    tick_model = 0;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_period = $urandom;
    check("busy_after_start", {31'h0, busy}, 32'h1);
    repeat (3) @(negedge clk);
  endtask

  // One serviced timeout. stop_off 1..5 pulses cfg_stop mid-service; glitch pulses a
  // cfg_start that must be ignored while busy.
  task automatic do_tick(input logic [31:0] val, input int gap, input int stop_off, input bit glitch);
    int t;
    tick_t e;
    repeat (gap) @(negedge clk);
    counter = val;
    t = cyc;
    irq = 1'b1;
    push_bus(t + 1, 3'd4, 1'b0, 16'h0);
    push_bus(t + 2, 3'd4, 1'b1, 16'h0);
    push_bus(t + 3, 3'd5, 1'b1, 16'h0);
    push_bus(t + 5, 3'd0, 1'b0, 16'h0);
    tick_model++;
    ticks_pushed++;
    e.c = t + 6; e.s = val; e.n = exp_cnt(tick_model);
    tick_q.push_back(e);
    if (stop_off > 0) push_bus(t + 7, 3'd1, 1'b0, 16'h0008);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      cfg_stop  = (k == stop_off);
      cfg_start = glitch && (k == 2);
      if (k == 6) irq = 1'b0;
    end
    if (stop_off > 0) begin
      @(negedge clk);
      check("busy_after_service_stop", {31'h0, busy}, 32'h0);
    end
  endtask

  // Stop from WAIT_IRQ, optionally racing a timeout in the same cycle.
  task automatic do_stop_wait(input int gap, input bit with_irq);
    int w;
    repeat (gap) @(negedge clk);
    w = cyc;
    cfg_stop = 1'b1;
    irq = with_irq;
    push_bus(w + 1, 3'd1, 1'b0, 16'h0008);
    @(negedge clk);
    cfg_stop = 1'b0;
    irq = 1'b0;
    @(negedge clk);
    check("busy_after_wait_stop", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int t;
    reset = 1'b1; sel = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; irq = 1'b0;
    cfg_period = 32'h0; counter = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Stop while idle must produce nothing.
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_stop_ignored", {31'h0, busy}, 32'h0);

    do_start(32'h0001_86A0);
    do_tick(32'h0001_2345, 2, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      do_tick($urandom, $urandom_range(0, 5), 0, 1'($urandom_range(0, 1)));
    check("count_after_wrap", {16'h0, cnt}, 32'd5);
    do_stop_wait(3, 1'b1);

    do_start($urandom);
    do_tick($urandom, 1, 3, 1'b0);

    do_start($urandom);
    for (int i = 0; i < 5; i++) do_tick($urandom, $urandom_range(0, 4), 0, 1'b0);
    do_tick($urandom, 0, $urandom_range(1, 5), 1'b0);

    do_start($urandom);
    do_tick($urandom, 1, 0, 1'b0);
    do_stop_wait($urandom_range(0, 6), 1'b0);

    // Reset in the middle of a service, during the first snapshot read.
    do_start($urandom);
    do_tick($urandom, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    counter = $urandom;
    t = cyc;
    irq = 1'b1;
    push_bus(t + 1, 3'd4, 1'b0, 16'h0);
    push_bus(t + 2, 3'd4, 1'b1, 16'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    irq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start(32'hCAFE_0042);
    do_tick($urandom, 2, 0, 1'b0);
    do_stop_wait(1, 1'b0);

    // One-shot instance: control word 0x0005, idle after one tick, deaf afterwards.
    sel = 1'b1;
    @(negedge clk);
    do_start($urandom);
    do_tick($urandom, 3, 0, 1'b0);
    check("oneshot_idle_after_tick", {31'h0, busy}, 32'h0);
    irq = 1'b1;
    repeat (10) @(negedge clk);
    irq = 1'b0;
    check("oneshot_stays_idle", {31'h0, busy}, 32'h0);
    check("oneshot_count_held", {16'h0, cnt}, 32'd1);

    repeat (3) @(negedge clk);
    check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
    check("tick_queue_drained", 32'(tick_q.size()), 32'h0);
    check("tick_pulse_total", 32'(ticks_seen), 32'(ticks_pushed));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dircc_timer_tick_master.md
# dircc_timer_tick_master

Avalon-MM master that owns one DiRCC node interval timer (16-bit-data, 3-bit-address register slave). It programs the timer's period and control registers on command, services every timeout interrupt by snapshotting and reading the live counter, then clearing the status register. It hands each tick to node logic as a 32-bit timestamp with a wrapping tick count. This replaces the software timer ISR on hardware-only nodes.

## Interface
- `CONTINUOUS`, default 1: 1 means the timer runs continuously (control CONT=1); 0 means one-shot, and the block returns to IDLE after the first tick.
- `COUNT_W`, default 16: width of `tick_count`.

Ports:
- `clk`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `cfg_start`, in, 1: start pulse; sampled only in IDLE.
- `cfg_period`, in, 32: timer reload value; latched on an accepted `cfg_start`.
- `cfg_stop`, in, 1: stop request pulse; latched while busy.
- `irq`, in, 1: timer interrupt; level, sampled only in WAIT_IRQ.
- `m_address`, out, 3: timer register word address.
- `m_chipselect`, out, 1: access strobe; exactly one cycle per access.
- `m_write_n`, out, 1: 0 means write.
- `m_writedata`, out, 16: write data.
- `m_readdata`, in, 16: timer read data; registered in the slave, valid the cycle after the address.
- `busy`, out, 1: high in every state except IDLE.
- `tick_valid`, out, 1: one-cycle pulse per serviced tick.
- `tick_snapshot`, out, 32: counter snapshot `{high, low}`; held between pulses.
- `tick_count`, out, COUNT_W: ticks since the last start; wraps to 0.

## Operation
- **Timer register map:**
  - 0 = status (any write clears the timeout flag)
  - 1 = control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP
  - 2/3 = period low/high
  - 4/5 = snapshot low/high (any write captures the counter)
- **Bus idle values:** `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
- The slave has no waitrequest. Every access completes in its single chipselect cycle.
- **States:** IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, WR_SNAP, RD_SL, RD_SH, CAP, WR_CLR, REPORT, WR_STOP.
- **IDLE:** on `cfg_start`, latch `cfg_period`, clear `tick_count` to 0 and clear stop_pending, then go to WR_PL.
- **WR_PL:** write address 2 with period[15:0], then go to WR_PH.
- **WR_PH:** write address 3 with period[31:16], then go to WR_CTRL. Period writes must precede START, because a period write stops the timer.
- **WR_CTRL:** write address 1 with 0x0007 (CONTINUOUS=1) or 0x0005 (CONTINUOUS=0), then go to WAIT_IRQ.
- **WAIT_IRQ:**
  - If stop_pending or `cfg_stop` is set, go to WR_STOP.
  - Else if `irq` is high, go to WR_SNAP.
  - Stop wins when both are set in the same cycle.
- **WR_SNAP:** write address 4 with data 0, then go to RD_SL.
- **RD_SL:** read address 4, then go to RD_SH.
- **RD_SH:** read address 5 and capture `m_readdata` as the low half, then go to CAP.
- **CAP:** capture `m_readdata` as the high half, with no bus access, then go to WR_CLR.
- **WR_CLR:** write address 0 with data 0, then go to REPORT.
- **REPORT:**
  - Assert `tick_valid`, update `tick_snapshot`, and increment `tick_count` (0xFFFF wraps to 0x0000 at the default width).
  - Next state: WR_STOP if stop_pending; IDLE if CONTINUOUS=0; otherwise WAIT_IRQ.
- **WR_STOP:** write address 1 with 0x0008 (STOP, ITO=0), clear stop_pending, then go to IDLE.
- `cfg_stop` asserted in any busy state other than WAIT_IRQ sets stop_pending. An in-flight service sequence always completes before the stop is issued.
- `cfg_stop` in IDLE is ignored. `cfg_start` while busy is ignored.
- **Reset, including mid-sequence:**
  - State returns to IDLE and bus outputs go to idle values.
  - `busy`=0, `tick_valid`=0, `tick_snapshot`=0, `tick_count`=0, stop_pending=0.
  - No bus cycle is truncated into a partial write, since each access is a single cycle.

## Timing
- **Start:** `cfg_start` accepted in cycle S; writes occur in S+1, S+2 and S+3; WAIT_IRQ is entered at S+4.
- **Service:** `irq` seen high in WAIT_IRQ at cycle T.
  - Snapshot write at T+1.
  - Reads at T+2 and T+3.
  - Low half captured at the end of T+3, high half at the end of T+4.
  - Status clear at T+5.
  - `tick_valid` at T+6.
  - Back in WAIT_IRQ at T+7.
- The timer drops `irq` the cycle after the status write, so WAIT_IRQ at T+7 never re-services the same event.
- Maximum serviceable tick rate is one per 7 cycles. Timeouts that occur during T+1..T+5 merge into the current service (they are not counted).
- `busy` is registered and rises the cycle after `cfg_start`.

## Test plan
- **Start sequence:** `cfg_period`=0x0001_86A0, pulse `cfg_start` -> three writes on consecutive cycles: (2, 0x86A0), (3, 0x0001), (1, 0x0007); `busy`=1 from S+1.
- **Single service:** with a timer model, raise `irq` at T with snapshot 0x0001_2345 -> writes at 4 and 0 occur; `tick_valid` pulses exactly at T+6 with `tick_snapshot`=0x0001_2345 and `tick_count`=1; `irq` low at T+6.
- **Wrap:** 65536 serviced ticks -> `tick_count` reads 0x0000 and `tick_valid` has pulsed 65536 times.
- **Stop races:**
  - `cfg_stop` and `irq` high in the same WAIT_IRQ cycle -> only (1, 0x0008) is issued, then IDLE, with no `tick_valid`.
  - `cfg_stop` during RD_SH -> the service completes with a `tick_valid` pulse, then (1, 0x0008), then IDLE.
- **One-shot:** CONTINUOUS=0 -> control write is 0x0005; after one tick, `busy`=0 and a later `irq` generates no bus traffic.
- **Reset mid-sequence:** assert `reset` during RD_SL -> all outputs return to reset values asynchronously; after release, a `cfg_start` reruns the start sequence from WR_PL.
